fifo_loader: RTL

//  Transmit side of the delay-buffer FIFO: captures one row of DEPTH words in
//  a single handshake, then drives the FIFO's d/en pins one word per cycle.

---
 rtl/fifo_loader.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fifo_loader.sv
// Transmit side of a row delay FIFO: latches a DEPTH-word row in one handshake,
// then emits optional leading zero beats followed by the row, one word per cycle.
module fifo_loader #(
    parameter int  DEPTH = 8,
    parameter int  BITS  = 64,
    localparam int SKW_W = $clog2(DEPTH + 1),
    localparam int CNT_W = $clog2(2 * DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DEPTH*BITS-1:0] in_data_i,
    input  logic [SKW_W-1:0]      in_skew_i,
    input  logic                  stall_i,
    output logic                  fifo_en_o,
    output logic [BITS-1:0]       fifo_d_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_W-1:0]      beat_cnt_o
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, PAD, SEND, DONE} state_e;

    state_e                        state_q, state_d;
    logic [DEPTH-1:0][BITS-1:0]    row_q, row_d;
    logic [SKW_W-1:0]              pad_q, pad_d;
    logic [SKW_W-1:0]              k_q, k_d;
    logic [CNT_W-1:0]              beat_q, beat_d;
    logic                          en_q, en_d;
    logic [BITS-1:0]               d_q, d_d;
    logic                          accept;
    logic [SKW_W-1:0]              skew_c;
    logic [IDX_W-1:0]              k_idx;

    assign accept = in_valid_i && in_ready_o;
    assign skew_c = (in_skew_i > SKW_W'(DEPTH)) ? SKW_W'(DEPTH) : in_skew_i;
    assign k_idx  = k_q[IDX_W-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            row_q   <= '0;
            pad_q   <= '0;
            k_q     <= '0;
            beat_q  <= '0;
            en_q    <= 1'b0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            pad_q   <= pad_d;
            k_q     <= k_d;
            beat_q  <= beat_d;
            en_q    <= en_d;
            d_q     <= d_d;
        end
    end

    // State names the beat being presented this cycle; the accept edge already emits beat 0.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (skew_c != '0) ? PAD : SEND;
            PAD:  if (!stall_i && pad_q == '0) state_d = SEND;
            SEND: if (!stall_i && k_q == SKW_W'(DEPTH)) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        row_d  = row_q;
        pad_d  = pad_q;
        k_d    = k_q;
        beat_d = beat_q;
        en_d   = 1'b0;
        d_d    = d_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    row_d  = in_data_i;
                    beat_d = '0;
                    en_d   = 1'b1;
                    if (skew_c != '0) begin
                        d_d   = '0;
                        pad_d = skew_c - 1'b1;
                        k_d   = '0;
                    end else begin
                        d_d   = in_data_i[BITS-1:0];
                        pad_d = '0;
                        k_d   = SKW_W'(1);
                    end
                end
            end
            PAD: begin
                // beat_cnt counts completed en cycles, so it reads 0 right after accept
                beat_d = beat_q + CNT_W'(en_q);
                if (!stall_i) begin
                    en_d = 1'b1;
                    if (pad_q != '0) begin
                        d_d   = '0;
                        pad_d = pad_q - 1'b1;
                    end else begin
                        d_d = row_q[0];
                        k_d = SKW_W'(1);
                    end
                end
            end
            SEND: begin
                beat_d = beat_q + CNT_W'(en_q);
                if (!stall_i && k_q != SKW_W'(DEPTH)) begin
                    en_d = 1'b1;
                    d_d  = row_q[k_idx];
                    k_d  = k_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready_o = (state_q == IDLE) && !rst_i;
        busy_o     = (state_q != IDLE);
        done_o     = (state_q == DONE);
    end

    assign fifo_en_o  = en_q;
    assign fifo_d_o   = d_q;
    assign beat_cnt_o = beat_q;
endmodule
